keypad_scanner: RTL

- Upstream stage of vending_machine. Drives the 4x4 hex keypad columns and samples the rows.
- Debounces presses and delivers one clean key event per press: a 4-bit key code plus a 1-cycle valid strobe.
- Its outputs drive vending_machine's key input; shift_col is also routed to the keypad pins.

---
 rtl/keypad_pkg.sv | 59 +++++
 rtl/keypad_sync.sv | 28 ++
 rtl/keypad_scanner.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types, constants and helpers for the 4x4 keypad scanner.
//   state_e          FSM state encoding (SCAN, DEBOUNCE, HELD, RELEASE)
//   COL0..COL3       one-hot-low column drive patterns
//   NO_KEY           idle row pattern (all rows pulled up)
//   KEY_*            key codes, laid out as {col_idx, row_idx}
//   onehot_low_idx   decodes a row pattern into a row index plus valid flag
//   col_drive        maps a column index to its drive pattern
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_e;

  localparam logic [3:0] COL0   = 4'b1110;
  localparam logic [3:0] COL1   = 4'b1101;
  localparam logic [3:0] COL2   = 4'b1011;
  localparam logic [3:0] COL3   = 4'b0111;
  localparam logic [3:0] NO_KEY = 4'b1111;

  localparam logic [3:0] KEY_0 = 4'h0;
  localparam logic [3:0] KEY_1 = 4'h1;
  localparam logic [3:0] KEY_E = 4'hE;
  localparam logic [3:0] KEY_F = 4'hF;

  typedef struct packed {
    logic       vld;
    logic [1:0] idx;
  } row_hit_t;

  // Exactly one low bit is a key; all-high or several lows (ghosting) is not.
  function automatic row_hit_t onehot_low_idx(input logic [3:0] pat);
    row_hit_t r;
    r.vld = 1'b1;
    r.idx = 2'd0;
    case (pat)
      4'b1110: r.idx = 2'd0;
      4'b1101: r.idx = 2'd1;
      4'b1011: r.idx = 2'd2;
      4'b0111: r.idx = 2'd3;
      default: r.vld = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] col_drive(input logic [1:0] idx);
    logic [3:0] c;
    case (idx)
      2'd0:    c = COL0;
      2'd1:    c = COL1;
      2'd2:    c = COL2;
      default: c = COL3;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// keypad_sync: 4-bit two-flop synchronizer for the asynchronous keypad rows.
//   clk_i   system clock
//   rst_ni  asynchronous active-low reset (outputs reset to 1111, i.e. no key)
//   d_i     raw row inputs
//   q_o     synchronized rows
module keypad_sync (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [3:0] d_i,
  output logic [3:0] q_o
);

  logic [3:0] meta_q;
  logic [3:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 4'b1111;
      sync_q <= 4'b1111;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 hex keypad, debounces press and release, and
// emits one key event per press.
//   clk        system clock
//   reset      asynchronous active-low reset
//   row        keypad rows, active-low
//   shift_col  column drive, one-hot-low (1110 = col0 ... 0111 = col3)
//   key_code   {col_idx, row_idx} of the last accepted key
//   key_valid  1-cycle strobe in the cycle key_code updates
//   key_held   high from acceptance until the release is accepted
// Build option: define KEYPAD_AUTOREPEAT_EN to re-strobe key_valid every
// REPEAT_CYCLES while a key stays held.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV        = 50000,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_CYCLES   = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] shift_col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  if (SCAN_DIV < 1 || DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 2) begin : g_cfg_check
    $error("keypad_scanner: invalid timing parameters");
  end

  localparam int unsigned DW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0]  DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [DBW-1:0] DEB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int unsigned RW = $clog2(REPEAT_CYCLES);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
  logic [RW-1:0] rep_q;
`endif

  logic [3:0]     rs;
  row_hit_t       rs_hit;
  state_e         state_q;
  logic [1:0]     col_q;
  logic [1:0]     col_d;
  logic [3:0]     shift_col_q;
  logic [DW-1:0]  dwell_q;
  logic [DBW-1:0] deb_q;
  logic [3:0]     pat_q;
  logic [1:0]     row_idx_q;
  logic [3:0]     key_code_q;
  logic           key_valid_q;
  logic           key_held_q;

  keypad_sync u_sync (
    .clk_i  (clk),
    .rst_ni (reset),
    .d_i    (row),
    .q_o    (rs)
  );

  assign rs_hit = onehot_low_idx(rs);
  assign col_d  = col_q + 2'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= SCAN;
      col_q       <= 2'd0;
      shift_col_q <= COL0;
      dwell_q     <= '0;
      deb_q       <= '0;
      pat_q       <= NO_KEY;
      row_idx_q   <= 2'd0;
      key_code_q  <= KEY_0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_q       <= '0;
`endif
    end else begin
      key_valid_q <= 1'b0;
      unique case (state_q)
        SCAN: begin
          // Rows are only trusted on the last dwell cycle, after the column
          // drive has had time to propagate through the synchronizer.
          if (dwell_q == DWELL_LAST) begin
            dwell_q <= '0;
            if (rs_hit.vld) begin
              pat_q     <= rs;
              row_idx_q <= rs_hit.idx;
              deb_q     <= '0;
              state_q   <= DEBOUNCE;
            end else begin
              col_q       <= col_d;
              shift_col_q <= col_drive(col_d);
            end
          end else begin
            dwell_q <= dwell_q + 1'b1;
          end
        end
        DEBOUNCE: begin
          if (rs == pat_q) begin
            if (deb_q == DEB_LAST) begin
              key_code_q  <= {col_q, row_idx_q};
              key_valid_q <= 1'b1;
              key_held_q  <= 1'b1;
              deb_q       <= '0;
              state_q     <= HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
              rep_q       <= '0;
`endif
            end else begin
              deb_q <= deb_q + 1'b1;
            end
          end else begin
            dwell_q     <= '0;
            col_q       <= col_d;
            shift_col_q <= col_drive(col_d);
            state_q     <= SCAN;
          end
        end
        HELD: begin
          if (rs != pat_q) begin
            deb_q   <= '0;
            state_q <= RELEASE;
          end
`ifdef KEYPAD_AUTOREPEAT_EN
          else if (rep_q == REP_LAST) begin
            key_valid_q <= 1'b1;
            rep_q       <= '0;
          end else begin
            rep_q <= rep_q + 1'b1;
          end
`endif
        end
        RELEASE: begin
          // Only an unbroken run of all-high rows counts as a release; the
          // original key reappearing is treated as bounce.
          if (rs == pat_q) begin
            state_q <= HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_q   <= '0;
`endif
          end else if (rs == NO_KEY) begin
            if (deb_q == DEB_LAST) begin
              key_held_q  <= 1'b0;
              deb_q       <= '0;
              dwell_q     <= '0;
              col_q       <= col_d;
              shift_col_q <= col_drive(col_d);
              state_q     <= SCAN;
            end else begin
              deb_q <= deb_q + 1'b1;
            end
          end else begin
            deb_q <= '0;
          end
        end
      endcase
    end
  end

  assign shift_col = shift_col_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule
